// File: rtl/soc_rr_dispatcher.sv
// Round-robin 1-to-N stream dispatcher.
// A single valid/ready producer feeds N one-entry registered output slots.
// The search for a free slot starts at ptr and wraps around. A slot that is
// being drained in the same cycle counts as free.
module soc_rr_dispatcher #(
  parameter int N  = 2,
  parameter int DW = 32,
  localparam int PW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [N*DW-1:0] out_data,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [PW-1:0]   ptr
);

  logic [N-1:0]    valid_q, valid_d;
  logic [N*DW-1:0] data_q, data_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic [N-1:0]    free;
  logic            any_free;
  logic            found;
  logic            accept;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   cand;
  int              scan_idx;

  // First free slot at or after ptr, wrapping from N-1 back to 0.
  always_comb begin
    free     = ~valid_q | out_ready;
    any_free = |free;
    sel      = ptr_q;
    found    = 1'b0;
    scan_idx = 0;
    cand     = '0;
    for (int i = 0; i < N; i++) begin
      scan_idx = int'(ptr_q) + i;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      cand = PW'(scan_idx);
      if (!found && free[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  // in_ready deliberately ignores in_valid; it depends only on en and slot state.
  assign in_ready = en & any_free;
  assign accept   = in_valid & in_ready;

  // Next slot contents and pointer. An accept into a slot overrides its drain.
  always_comb begin
    valid_d = valid_q & ~out_ready;
    data_d  = data_q;
    ptr_d   = ptr_q;
    if (accept) begin
      valid_d[sel]                = 1'b1;
      data_d[int'(sel)*DW +: DW]  = in_data;
      ptr_d = (sel == PW'(N-1)) ? '0 : sel + 1'b1;
    end
  end

  // State registers with synchronous reset that discards all slot words.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ptr       = ptr_q;

endmodule

// File: tb/tb_soc_rr_dispatcher.sv
// Testbench for soc_rr_dispatcher (N=4, DW=8): directed scenarios followed by
// randomized traffic, all checked against a slot-array reference model.
module tb_soc_rr_dispatcher;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic [DW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] out_data;
  logic [N-1:0]    out_valid;
  logic [N-1:0]    out_ready;
  logic [1:0]      ptr;

  soc_rr_dispatcher #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ptr       (ptr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int n_drn    = 0;

  // Reference model: per-channel slot contents and rotating start index.
  bit            m_valid [N];
  logic [DW-1:0] m_data  [N];
  int            m_ptr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: check in_ready, advance model, then compare registered outputs.
  task automatic step();
    int            sel;
    bit            exp_rdy;
    logic [N-1:0]  ev;
    logic [N*DW-1:0] ed;
    #1;
    sel = -1;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (m_ptr + i) % N;
      if (sel < 0 && (!m_valid[k] || out_ready[k])) sel = k;
    end
    exp_rdy = en && (sel >= 0);
    if (!rst) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
      if (in_valid && in_ready) n_acc++;
      n_drn += $countones(out_valid & out_ready);
    end
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_valid[k] = 1'b0;
        m_data[k]  = '0;
      end
      m_ptr = 0;
    end else begin
      for (int k = 0; k < N; k++)
        if (m_valid[k] && out_ready[k]) m_valid[k] = 1'b0;
      if (in_valid && exp_rdy) begin
        m_valid[sel] = 1'b1;
        m_data[sel]  = in_data;
        m_ptr        = (sel + 1) % N;
      end
    end
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      ev[k]          = m_valid[k];
      ed[k*DW +: DW] = m_data[k];
    end
    chk("out_valid", {60'd0, out_valid}, {60'd0, ev});
    chk("out_data", {32'd0, out_data}, {32'd0, ed});
    chk("ptr", {62'd0, ptr}, 64'(m_ptr));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    rst      = 1'b0;
  endtask

  initial begin
    logic [3:0] onehot;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = '0;
    for (int k = 0; k < N; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
    end
    m_ptr = 0;

    // Reset state
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_valid", {60'd0, out_valid}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_ptr", {62'd0, ptr}, 64'd0);
    chk("rst_rdy", {63'd0, in_ready}, 64'd1);

    // Fill with all consumers ready: channels 0,1,2,3,0,1
    out_ready = 4'hF;
    in_valid  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'(8'h10 + i);
      step();
      onehot = 4'b0001 << (i % 4);
      chk("fill_valid", {60'd0, out_valid}, {60'd0, onehot});
      chk("fill_data", {56'd0, out_data[(i%4)*DW +: DW]}, 64'(8'h10 + i));
      chk("fill_ptr", {62'd0, ptr}, 64'((i + 1) % 4));
    end

    // Skip busy: only channel 1 loaded, ptr=1, word 0xA5 lands in channel 2
    do_reset();
    out_ready = '0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h20 + i);
      step();
    end
    in_valid = 1'b0; out_ready = 4'b1101;
    step();
    in_valid = 1'b1; out_ready = 4'b0000; in_data = 8'h26;
    step();
    in_valid = 1'b0; out_ready = 4'b0001;
    step();
    chk("skip_pre_ptr", {62'd0, ptr}, 64'd1);
    in_valid = 1'b1; out_ready = 4'b0000; in_data = 8'hA5;
    step();
    chk("skip_ptr", {62'd0, ptr}, 64'd3);
    chk("skip_ch2", {56'd0, out_data[2*DW +: DW]}, 64'hA5);
    chk("skip_ch1", {56'd0, out_data[1*DW +: DW]}, 64'h21);
    chk("skip_valid", {60'd0, out_valid}, 64'b0110);

    // Full: no ready after 4 words; releasing channel 2 lets 0x55 replace it
    do_reset();
    out_ready = '0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'h30 + i);
      step();
    end
    in_data = 8'h99;
    #1;
    chk("full_rdy", {63'd0, in_ready}, 64'd0);
    step();
    out_ready = 4'b0100; in_data = 8'h55;
    #1;
    chk("full_rdy2", {63'd0, in_ready}, 64'd1);
    step();
    chk("full_ch2", {56'd0, out_data[2*DW +: DW]}, 64'h55);
    chk("full_valid", {60'd0, out_valid}, 64'hF);
    chk("full_ptr", {62'd0, ptr}, 64'd3);

    // Enable gating: slots drain but nothing is accepted
    en = 1'b0; in_valid = 1'b1; out_ready = 4'hF; in_data = 8'h77;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_ptr", {62'd0, ptr}, 64'd3);
      chk("en_rdy", {63'd0, in_ready}, 64'd0);
    end
    chk("en_drained", {60'd0, out_valid}, 64'd0);
    en = 1'b1;
    step();
    chk("en_valid", {60'd0, out_valid}, 64'b1000);
    chk("en_ch3", {56'd0, out_data[3*DW +: DW]}, 64'h77);
    chk("en_ptr2", {62'd0, ptr}, 64'd0);

    // Mid-stream reset with three slots valid
    out_ready = '0; in_valid = 1'b1;
    in_data = 8'h81; step();
    in_data = 8'h82; step();
    chk("mid_pre", {60'd0, out_valid}, 64'b1011);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_valid", {60'd0, out_valid}, 64'd0);
    chk("mid_data", {32'd0, out_data}, 64'd0);
    chk("mid_ptr", {62'd0, ptr}, 64'd0);

    // Randomized traffic against the model, plus word conservation
    n_acc = 0;
    n_drn = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 15) != 0);
      out_ready = 4'($urandom);
      in_data   = 8'($urandom);
      step();
    end
    chk("conserve", 64'(n_acc), 64'(n_drn + $countones(out_valid)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/soc_rr_dispatcher.md
# soc_rr_dispatcher

Round-robin 1-to-N stream dispatcher: accepts words from a single valid/ready producer and distributes them across N consumer channels in rotating order, skipping channels whose output slot is occupied. It is the fan-out counterpart of the SoC round-robin arbiter and sits between a shared request source (DMA engine, NoC ingress) and N per-core or per-slave queues. Each channel has a one-entry registered output slot, so every output is driven straight from a flop.

## Interface
- N, default 2: number of output channels, N ≥ 2.
- DW, default 32: data width in bits.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- en  input  1  dispatch enable; when 0, no input word is accepted, but already-loaded slots still drain.
- in_data  input  DW  input word.
- in_valid  input  1  input word present.
- in_ready  output  1  dispatcher accepts in_data this cycle.
- out_data  output  N*DW  channel k data in bits [k*DW +: DW]; registered.
- out_valid  output  N  channel k slot holds a word; registered.
- out_ready  input  N  channel k consumer takes the slot word this cycle.
- ptr  output  $clog2(N)  current round-robin start index (debug/verification visibility).

## Operation
- State:
  - per-channel slot (data register plus valid bit);
  - round-robin pointer ptr in the range 0..N-1.
- Slot k is free when `~out_valid[k] | out_ready[k]`. A slot being drained in the same cycle counts as free, so back-to-back reuse of a channel is allowed.
- Selection:
  - Scan from ptr upward, wrapping from N-1 to 0.
  - sel is the first free slot.
  - any_free means at least one slot is free.
- `in_ready = en & any_free`. in_ready is combinational from out_valid, out_ready, en and ptr. It must not depend on in_valid.
- Accept occurs when `in_valid & in_ready`. On an accept:
  - slot[sel] data ← in_data;
  - out_valid[sel] ← 1;
  - ptr ← (sel + 1) mod N, wrapping correctly for non-power-of-2 N.
- Drain occurs when `out_valid[k] & out_ready[k]` and there is no accept into k in the same cycle. Then out_valid[k] ← 0.
- Simultaneous drain and accept on the same k: out_valid[k] stays 1 and the data is replaced with the new word.
- No accept: ptr holds its value.
- While out_valid[k] = 1 and out_ready[k] = 0, out_data[k] is stable (standard valid/ready persistence).
- Words are never dropped or duplicated.
- Ordering across channels is the round-robin order of acceptance only. There is no reordering guarantee between consumers.
- Reset:
  - out_valid = 0 on all channels;
  - out_data = 0;
  - ptr = 0.
  - With en = 1, in_ready = 1 in the first cycle after reset.
  - Reset asserted mid-operation discards every slot word in that same edge.

## Timing
- Latency: one cycle. A word accepted at edge t is visible on out_data/out_valid after edge t.
- Throughput: one word per cycle while any slot is free.
- Full condition: all slots have out_valid = 1 and out_ready = 0. Then in_ready = 0, and ptr and all slots hold.
- Empty condition: all out_valid = 0. Then sel = ptr.
- en deassertion takes effect in the same cycle: in_ready falls and no accept happens.

## Test plan
All scenarios use N=4, DW=8.

- Reset/fill, all out_ready=1, in_valid=1, data 0x10,0x11,0x12,… → data goes to channels 0,1,2,3,0,1 on consecutive cycles; out_valid is one-hot on successive cycles; ptr sequence is 1,2,3,0,1,2; in_ready stays 1.
- Skip busy, out_ready=0, channel 1 preloaded and the other slots empty, ptr=1 → next word 0xA5 lands in channel 2 and ptr becomes 3; channel 1 data is unchanged.
- Full, all out_ready=0, with 4 words pushed → in_ready=0 on the 5th cycle. Raising only out_ready[2] makes in_ready=1; the 5th word 0x55 replaces channel 2 in the same edge and out_valid[2] stays 1.
- Enable gating, en=0 with in_valid=1 for 3 cycles → no accept, ptr unchanged, existing slots drain normally. With en=1 the next edge accepts.
- Mid-stream reset, rst=1 while 3 slots are valid → after the edge all out_valid=0, out_data=0, ptr=0.
- Random scoreboard: random in_valid and out_ready for 10k cycles → every accepted word appears exactly once on some channel; no channel's data changes while valid && !ready.
